// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl: iterative DES key schedule, one PC-2 subkey per handshake in encrypt or decrypt order
module des_key_sched_ctrl #(
  parameter bit PARITY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic        abort,
  input  logic        sk_ready,
  output logic        sk_valid,
  output logic [47:0] sk,
  output logic [3:0]  sk_round,
  output logic        busy,
  output logic        done,
  output logic        key_err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction
  function automatic logic odd_par(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) ok = ok & (^k[8*i +: 8]);
    return ok;
  endfunction
  function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic one);
    return left ? (one ? {x[26:0], x[27]} : {x[25:0], x[27:26]})
                : (one ? {x[0], x[27:1]} : {x[1:0], x[27:2]});
  endfunction
  state_t      state;
  logic [27:0] c, d;
  logic [3:0]  cnt, nxt;
  logic        dec, sh1, par_ok;
  logic [55:0] p;
  assign p = pc1(key);
  assign nxt = cnt + 4'd1;
  // single-bit shifts fall on the same steps in both directions
  assign sh1 = (nxt == 4'd1) || (nxt == 4'd8) || (nxt == 4'd15);
  assign par_ok = !PARITY_CHECK || odd_par(key);
  assign sk_valid = (state == RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sk = pc2({c, d});
  assign sk_round = dec ? 4'd15 - cnt : cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c <= '0;
      d <= '0;
      cnt <= '0;
      dec <= 1'b0;
      key_err <= 1'b0;
    end else begin
      key_err <= 1'b0;
      if (abort) state <= IDLE;
      else begin
        case (state)
          IDLE: if (start) begin
            if (par_ok) begin
              c <= decrypt ? p[55:28] : rot(p[55:28], 1'b1, 1'b1);
              d <= decrypt ? p[27:0] : rot(p[27:0], 1'b1, 1'b1);
              dec <= decrypt;
              cnt <= '0;
              state <= RUN;
            end else key_err <= 1'b1;
          end
          RUN: if (sk_ready) begin
            if (cnt == 4'd15) state <= DONE;
            else begin
              cnt <= nxt;
              c <= rot(c, !dec, sh1);
              d <= rot(d, !dec, sh1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
